mem_stage: RTL and testbench

- MEM pipeline stage between the EX_MEM latch and the MEM_WB path.
- Executes RV32I loads and stores over the 8-bit byte-serial RAM port; passes ALU results through.
- Produces the MEM-side forwarding triple (forward_mem_enable/addr/data) consumed by ID_EX.
- Raises stall_req while a multi-cycle memory access is in flight.

---
 rtl/mem_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial RV32I loads and stores over an 8-bit RAM port,
// ALU pass-through, MEM-side forwarding and a registered writeback slot.
module mem_stage #(
    parameter int         ADDR_W   = 32,
    parameter logic [6:0] OP_LOAD  = 7'b0000011,
    parameter logic [6:0] OP_STORE = 7'b0100011
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              ex_valid,
    input  logic [4:0]        ex_rd_addr,
    input  logic [31:0]       ex_data,
    input  logic [31:0]       ex_store_data,
    input  logic [6:0]        ex_ins_type,
    input  logic [2:0]        ex_ins_details,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic              stall_req,
    output logic              forward_mem_enable,
    output logic [4:0]        forward_mem_addr,
    output logic [31:0]       forward_mem_data,
    output logic              wb_enable,
    output logic [4:0]        wb_rd_addr,
    output logic [31:0]       wb_data
);

    // EX_MEM handshake: the slot is consumed on every edge with rdy_in high and
    // stall_req low; while stall_req is high the upstream latch must hold its contents.
    typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_TAIL, S_WR, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [1:0]          last_q, last_d;
    logic                uns_q, uns_d;
    logic                is_load_q, is_load_d;
    logic [4:0]          rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         sdata_q, sdata_d;
    logic [31:0]         buf_q, buf_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                mem_wr_q, mem_wr_d;
    logic                wb_en_q, wb_en_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic [31:0]         wb_data_q, wb_data_d;

    logic                is_mem_op;
    logic                is_load_op;
    logic [31:0]         load_value;

    // Index of the last byte of an access: 0, 1 or 3 (unlisted widths act as W).
    function automatic logic [1:0] last_idx(input logic [2:0] f3);
        logic [1:0] r;
        case (f3[1:0])
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        logic [31:0] s;
        s = w >> {idx, 3'b000};
        return s[7:0];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] last,
                                             input logic uns);
        logic [31:0] r;
        case (last)
            2'd0:    r = {{24{w[7] & ~uns}}, w[7:0]};
            2'd1:    r = {{16{w[15] & ~uns}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        is_mem_op  = ex_valid && (ex_ins_type == OP_LOAD || ex_ins_type == OP_STORE);
        is_load_op = (ex_ins_type == OP_LOAD);
        load_value = load_ext(buf_q, last_q, uns_q);

        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        uns_d      = uns_q;
        is_load_d  = is_load_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = 1'b0;
        wb_en_d    = wb_en_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;

        stall_req          = 1'b0;
        forward_mem_enable = 1'b0;
        forward_mem_addr   = 5'd0;
        forward_mem_data   = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (is_mem_op) begin
                    stall_req = 1'b1;
                    addr_d    = ex_data[ADDR_W-1:0];
                    last_d    = last_idx(ex_ins_details);
                    uns_d     = ex_ins_details[2];
                    is_load_d = is_load_op;
                    rd_d      = ex_rd_addr;
                    sdata_d   = ex_store_data;
                    buf_d     = 32'd0;
                    cnt_d     = 2'd0;
                    wb_en_d   = 1'b0;
                    mem_a_d   = ex_data[ADDR_W-1:0];
                    if (is_load_op) begin
                        state_d = S_RD;
                    end else begin
                        state_d    = S_WR;
                        mem_dout_d = ex_store_data[7:0];
                        mem_wr_d   = 1'b1;
                    end
                end else begin
                    wb_en_d   = ex_valid && (ex_rd_addr != 5'd0);
                    wb_rd_d   = ex_rd_addr;
                    wb_data_d = ex_data;
                    if (ex_valid && ex_rd_addr != 5'd0) begin
                        forward_mem_enable = 1'b1;
                        forward_mem_addr   = ex_rd_addr;
                        forward_mem_data   = ex_data;
                    end
                end
            end
            S_RD: begin
                stall_req = 1'b1;
                // RAM returns a byte one cycle after its address, so lane cnt-1 lands now.
                if (cnt_q != 2'd0) buf_d = put_byte(buf_q, cnt_q - 2'd1, mem_din);
                if (cnt_q == last_q) begin
                    state_d = S_RD_TAIL;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    mem_a_d = addr_q + ADDR_W'(cnt_d);
                end
            end
            S_RD_TAIL: begin
                stall_req = 1'b1;
                buf_d     = put_byte(buf_q, last_q, mem_din);
                state_d   = S_DONE;
            end
            S_WR: begin
                stall_req = 1'b1;
                if (cnt_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    mem_a_d    = addr_q + ADDR_W'(cnt_d);
                    mem_dout_d = byte_of(sdata_q, cnt_d);
                    mem_wr_d   = 1'b1;
                end
            end
            S_DONE: begin
                if (is_load_q) begin
                    wb_en_d   = (rd_q != 5'd0);
                    wb_rd_d   = rd_q;
                    wb_data_d = load_value;
                    if (rd_q != 5'd0) begin
                        forward_mem_enable = 1'b1;
                        forward_mem_addr   = rd_q;
                        forward_mem_data   = load_value;
                    end
                end else begin
                    wb_en_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            uns_q      <= 1'b0;
            is_load_q  <= 1'b0;
            rd_q       <= 5'd0;
            addr_q     <= '0;
            sdata_q    <= 32'd0;
            buf_q      <= 32'd0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            uns_q      <= uns_d;
            is_load_q  <= is_load_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign mem_wr     = mem_wr_q & rdy_in;
    assign wb_enable  = wb_en_q;
    assign wb_rd_addr = wb_rd_q;
    assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random ops, checked against a
// byte-array RAM and an arithmetic load/store model.
module tb_mem_stage;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0010011;

    logic        clk_in, rst_in, rdy_in;
    logic        ex_valid;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_data, ex_store_data;
    logic [6:0]  ex_ins_type;
    logic [2:0]  ex_ins_details;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, stall_req;
    logic        forward_mem_enable;
    logic [4:0]  forward_mem_addr;
    logic [31:0] forward_mem_data;
    logic        wb_enable;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;

    int          vectors;
    int          miscompares;
    logic [39:0] exp_q[$];
    logic [7:0]  ram [0:1023];

    mem_stage dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_data(ex_data),
        .ex_store_data(ex_store_data), .ex_ins_type(ex_ins_type),
        .ex_ins_details(ex_ins_details), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .stall_req(stall_req),
        .forward_mem_enable(forward_mem_enable), .forward_mem_addr(forward_mem_addr),
        .forward_mem_data(forward_mem_data), .wb_enable(wb_enable),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Byte RAM: registered read (frozen with the rest of the system), write on strobe.
    always @(posedge clk_in) begin
        if (rdy_in) mem_din <= ram[mem_a[9:0]];
        if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        int          n;
        logic [31:0] v, ai;
        n = size_of(f3);
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            v  = v | (32'(ram[ai[9:0]]) << (8 * i));
        end
        if (n == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
        if (n == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic idle_cycle();
        ex_valid = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    // Presents one op, holds it while stall_req is high, checks writes, stall
    // length, forwarding and writeback. Optionally drops rdy_in for frz_len
    // cycles once frz_at stall cycles have elapsed.
    task automatic run_op(input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] data,
                          input logic [31:0] sdata, input int frz_at, input int frz_len);
        bit          is_mem, is_ld, done, frz_done;
        int          n, exp_stall, n_stall, frz_left;
        logic [31:0] ld_val, a_hold, ai;
        logic        exp_fen, exp_wen;
        logic [4:0]  exp_fa;
        logic [31:0] exp_fd;
        logic [39:0] w;

        is_mem = v && (op == OP_LOAD || op == OP_STORE);
        is_ld  = is_mem && (op == OP_LOAD);
        n      = size_of(f3);
        ld_val = ref_load(data, f3);
        if (!is_mem)    exp_stall = 0;
        else if (is_ld) exp_stall = n + 2 + frz_len;
        else            exp_stall = n + 1 + frz_len;
        if (is_mem && !is_ld)
            for (int i = 0; i < n; i++) begin
                ai = data + 32'(i);
                exp_q.push_back({ai, 8'(sdata >> (8 * i))});
            end
        if (is_ld)       exp_fen = (rd != 5'd0);
        else if (is_mem) exp_fen = 1'b0;
        else             exp_fen = v && (rd != 5'd0);
        exp_fa = exp_fen ? rd : 5'd0;
        exp_fd = exp_fen ? (is_ld ? ld_val : data) : 32'd0;
        exp_wen = is_ld ? (rd != 5'd0) : (!is_mem && v && rd != 5'd0);

        ex_valid = v; ex_ins_type = op; ex_ins_details = f3;
        ex_rd_addr = rd; ex_data = data; ex_store_data = sdata;

        n_stall = 0; frz_left = 0; done = 0; frz_done = 0; a_hold = 32'd0;
        while (!done) begin
            @(negedge clk_in);
            if (mem_wr) begin
                check("wr_expected", 40'(exp_q.size() != 0), 40'd1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("wr_addr_byte", {mem_a, mem_dout}, w);
                end
            end
            if (frz_left > 0) begin
                check("frozen_mem_a", 40'(mem_a), 40'(a_hold));
                check("frozen_mem_wr", 40'(mem_wr), 40'd0);
            end
            if (stall_req) begin
                n_stall++;
                check("fwd_during_stall", 40'(forward_mem_enable), 40'd0);
            end else begin
                done = 1;
                check("fwd_enable", 40'(forward_mem_enable), 40'(exp_fen));
                check("fwd_addr", 40'(forward_mem_addr), 40'(exp_fa));
                check("fwd_data", 40'(forward_mem_data), 40'(exp_fd));
            end
            if (n_stall > 30) begin
                check("stall_timeout", 40'(n_stall), 40'(exp_stall));
                done = 1;
            end
            @(posedge clk_in);
            #1;
            if (frz_left > 0) begin
                frz_left--;
                if (frz_left == 0) rdy_in = 1'b1;
            end else if (frz_len > 0 && n_stall == frz_at && !frz_done) begin
                rdy_in = 1'b0; frz_left = frz_len; frz_done = 1; a_hold = mem_a;
            end
        end
        rdy_in = 1'b1;
        check("stall_cycles", 40'(n_stall), 40'(exp_stall));
        check("wb_enable", 40'(wb_enable), 40'(exp_wen));
        if (is_ld || !is_mem) begin
            check("wb_rd_addr", 40'(wb_rd_addr), 40'(rd));
            check("wb_data", 40'(wb_data), 40'(is_ld ? ld_val : data));
        end
        if (is_mem && !is_ld) check("wr_count", 40'(exp_q.size()), 40'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [2:0]  f3_tab [7];
        logic [31:0] a, d;
        logic [2:0]  f3;
        int          sel;

        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        vectors = 0; miscompares = 0;
        rst_in = 1'b1; rdy_in = 1'b1; ex_valid = 1'b0; ex_rd_addr = 5'd0;
        ex_data = 32'd0; ex_store_data = 32'd0; ex_ins_type = 7'd0; ex_ins_details = 3'd0;
        for (int i = 0; i < 1024; i++) ram[i] <= 8'($urandom);

        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_mem_wr", 40'(mem_wr), 40'd0);
        check("rst_mem_a", 40'(mem_a), 40'd0);
        check("rst_mem_dout", 40'(mem_dout), 40'd0);
        check("rst_stall", 40'(stall_req), 40'd0);
        check("rst_wb", {3'd0, wb_enable, wb_rd_addr, wb_data}, 40'd0);
        check("rst_fwd_en", 40'(forward_mem_enable), 40'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // ALU pass-through, then SW / LW round trip
        run_op(1'b1, OP_ALU, 3'd0, 5'd5, 32'h1234, 32'd0, 0, 0);
        run_op(1'b1, OP_STORE, 3'd2, 5'd0, 32'h100, 32'hAABBCCDD, 0, 0);
        run_op(1'b1, OP_LOAD, 3'd2, 5'd9, 32'h100, 32'd0, 0, 0);
        check("sw_bytes", 40'({ram[259], ram[258], ram[257], ram[256]}), 40'hAABBCCDD);

        ram[512] <= 8'h78; ram[513] <= 8'h56; ram[514] <= 8'h34; ram[515] <= 8'h12;
        ram[528] <= 8'h80; ram[544] <= 8'hFF; ram[545] <= 8'h7F;
        idle_cycle();
        run_op(1'b1, OP_LOAD, 3'd2, 5'd7, 32'h200, 32'd0, 0, 0);
        check("lw_value", 40'(wb_data), 40'h12345678);
        run_op(1'b1, OP_LOAD, 3'd0, 5'd3, 32'h210, 32'd0, 0, 0);
        check("lb_value", 40'(wb_data), 40'hFFFFFF80);
        run_op(1'b1, OP_LOAD, 3'd4, 5'd4, 32'h210, 32'd0, 0, 0);
        check("lbu_value", 40'(wb_data), 40'h00000080);
        run_op(1'b1, OP_LOAD, 3'd1, 5'd6, 32'h220, 32'd0, 0, 0);
        check("lh_value", 40'(wb_data), 40'h00007FFF);

        // LW frozen for 3 cycles after its first byte address
        run_op(1'b1, OP_LOAD, 3'd2, 5'd8, 32'h200, 32'd0, 2, 3);
        check("lw_frozen_value", 40'(wb_data), 40'h12345678);

        // Address wrap past 2^32
        run_op(1'b1, OP_STORE, 3'd2, 5'd0, 32'hFFFF_FFFE, 32'h0BADF00D, 0, 0);
        run_op(1'b1, OP_LOAD, 3'd2, 5'd2, 32'hFFFF_FFFE, 32'd0, 0, 0);
        check("wrap_value", 40'(wb_data), 40'h0BADF00D);

        // Reset in the middle of a SW
        ram[771] <= 8'h5A;
        idle_cycle();
        ex_valid = 1'b1; ex_ins_type = OP_STORE; ex_ins_details = 3'd2;
        ex_rd_addr = 5'd0; ex_data = 32'h300; ex_store_data = 32'h11223344;
        @(negedge clk_in);
        check("rst_sw_accept_stall", 40'(stall_req), 40'd1);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("rst_sw_byte0", {7'd0, mem_wr, mem_a, mem_dout}, {7'd0, 1'b1, 32'h300, 8'h44});
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("rst_sw_byte1", {7'd0, mem_wr, mem_a, mem_dout}, {7'd0, 1'b1, 32'h301, 8'h33});
        @(posedge clk_in); #1;
        rst_in = 1'b1; ex_valid = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_abort_mem_wr", 40'(mem_wr), 40'd0);
        check("rst_abort_stall", 40'(stall_req), 40'd0);
        check("rst_abort_mem_a", 40'(mem_a), 40'd0);
        check("rst_abort_dout", 40'(mem_dout), 40'd0);
        check("rst_abort_wb", {3'd0, wb_enable, wb_rd_addr, wb_data}, 40'd0);
        check("rst_abort_fwd", 40'(forward_mem_enable), 40'd0);
        @(posedge clk_in); #1;
        check("rst_abort_no_last_byte", 40'(ram[771]), 40'h5A);
        run_op(1'b1, OP_LOAD, 3'd2, 5'd0, 32'h300, 32'd0, 0, 0);
        run_op(1'b1, OP_ALU, 3'd0, 5'd0, 32'hDEAD, 32'd0, 0, 0);
        run_op(1'b0, OP_LOAD, 3'd2, 5'd3, 32'h40, 32'd0, 0, 0);

        // Random mix of ALU ops, loads and stores
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 1019));
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            d = $urandom;
            f3 = f3_tab[$urandom_range(0, 6)];
            if (sel < 4)
                run_op($urandom_range(0, 5) != 0, OP_ALU, f3, 5'($urandom_range(0, 31)),
                       d, 32'd0, 0, 0);
            else if (sel < 7)
                run_op(1'b1, OP_LOAD, f3, 5'($urandom_range(0, 31)), a, 32'd0, 0, 0);
            else
                run_op(1'b1, OP_STORE, 3'($urandom_range(0, 2)), 5'($urandom_range(0, 31)),
                       a, d, 0, 0);
        end

        idle_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
